// File: rtl/pid_pwm_pkg.sv
// Shared constants and the u(n) scale/saturate helper for pid_pwm_out.
package pid_pwm_pkg;

  localparam int unsigned SAT_LO = 0;
  localparam int unsigned SAT_HI = 1;

  localparam int unsigned CNT_NB_DEF    = 16;
  localparam int unsigned PERIOD_DEF    = 1000;
  localparam int unsigned UN_SHIFT_DEF  = 16;
  localparam int unsigned DT_CYCLES_DEF = 8;

  typedef logic [1:0] sat_flags_t;

  // Returns the clamped duty (0..period); flags report which rail was hit.
  function automatic logic [31:0] saturate(input  logic signed [31:0] un,
                                           input  int unsigned        shift,
                                           input  int unsigned        period,
                                           output sat_flags_t         flags);
    logic signed [31:0] s;
    logic        [31:0] duty;
    s     = un >>> shift;
    flags = '0;
    duty  = '0;
    if (s < 0) begin
      flags[SAT_LO] = 1'b1;
    end else if ($unsigned(s) > period) begin
      flags[SAT_HI] = 1'b1;
      duty          = period;
    end else begin
      duty = $unsigned(s);
    end
    return duty;
  endfunction

endpackage

// File: rtl/pid_pwm_out_deadtime.sv
// Dead-time inserter: each output rises only after its raw level has held
// DT_CYCLES clocks, and falls at once; both outputs are never high together.
module pwm_deadtime #(
  parameter int unsigned DT_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_raw,
  output logic o_pwm,
  output logic o_pwm_n
);

  localparam int unsigned   RW      = $clog2(DT_CYCLES + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(DT_CYCLES + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          last;

  // run counts consecutive clocks of the current raw level, saturating at RUN_MAX
  always_comb begin
    run_nxt = RW'(1);
    if (run != '0 && i_raw == last) begin
      run_nxt = (run == RUN_MAX) ? run : run + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run     <= '0;
      last    <= 1'b0;
      o_pwm   <= 1'b0;
      o_pwm_n <= 1'b0;
    end else if (!i_en) begin
      run     <= '0;
      last    <= 1'b0;
      o_pwm   <= 1'b0;
      o_pwm_n <= 1'b0;
    end else begin
      run     <= run_nxt;
      last    <= i_raw;
      o_pwm   <= i_raw && (run_nxt == RUN_MAX);
      o_pwm_n <= !i_raw && (run_nxt == RUN_MAX);
    end
  end

endmodule

// File: rtl/pid_pwm_out.sv
// Period-aligned PWM driven by the saturated PID control word u(n).
// Define PID_PWM_DEADTIME_EN to insert dead time between o_pwm and o_pwm_n.
module pid_pwm_out
  import pid_pwm_pkg::*;
#(
  parameter int unsigned CNT_NB    = CNT_NB_DEF,
  parameter int unsigned PERIOD    = PERIOD_DEF,
  parameter int unsigned UN_SHIFT  = UN_SHIFT_DEF,
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_un,
  input  logic              i_valid,
  input  logic              i_en,
  output logic              o_pwm,
  output logic              o_pwm_n,
  output logic [CNT_NB-1:0] o_duty,
  output logic [1:0]        o_sat,
  output logic              o_period_start
);

  logic [CNT_NB-1:0] cnt;
  logic [CNT_NB-1:0] pending;
  logic [CNT_NB-1:0] active;
  logic              pending_flag;
  logic              en_d;
  logic [1:0]        sat;
  logic              period_start;

  logic [CNT_NB-1:0] sat_duty;
  sat_flags_t        sat_flags;
  logic [CNT_NB-1:0] load_val;
  logic [CNT_NB-1:0] duty_cmp;
  logic              wrap;
  logic              first_en;
  logic              boundary;
  logic              raw;

  // A first-enable edge opens a new period at cnt 0, so the freshly loaded duty
  // must already drive that cycle's compare; on a wrap the old duty finishes PERIOD-1.
  always_comb begin
    sat_flags = '0;
    sat_duty  = CNT_NB'(saturate(i_un, UN_SHIFT, PERIOD, sat_flags));
    wrap      = i_en && (cnt == CNT_NB'(PERIOD - 1));
    first_en  = i_en && !en_d;
    boundary  = wrap || first_en;
    load_val  = i_valid ? sat_duty : (pending_flag ? pending : active);
    duty_cmp  = first_en ? load_val : active;
    raw       = cnt < duty_cmp;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
      active       <= '0;
      en_d         <= 1'b0;
      sat          <= '0;
      period_start <= 1'b0;
    end else begin
      en_d         <= i_en;
      cnt          <= (!i_en || wrap) ? '0 : cnt + 1'b1;
      period_start <= i_en && (cnt == '0);
      if (i_valid) sat <= sat_flags;
      if (boundary) begin
        active       <= load_val;
        pending_flag <= 1'b0;
      end else if (i_valid) begin
        pending      <= sat_duty;
        pending_flag <= 1'b1;
      end
    end
  end

`ifdef PID_PWM_DEADTIME_EN
  pwm_deadtime #(
    .DT_CYCLES(DT_CYCLES)
  ) u_deadtime (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en),
    .i_raw  (raw),
    .o_pwm  (o_pwm),
    .o_pwm_n(o_pwm_n)
  );
`else
  logic pwm_q;
  logic pwm_n_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      pwm_q   <= i_en && raw;
      pwm_n_q <= i_en && !raw;
    end
  end

  assign o_pwm   = pwm_q;
  assign o_pwm_n = pwm_n_q;
`endif

  assign o_duty         = active;
  assign o_sat          = sat;
  assign o_period_start = period_start;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Bench for pid_pwm_out: per-cycle behavioural model plus directed period measurements.
// Build with PID_PWM_DEADTIME_EN to exercise the dead-time variant.
module tb_pid_pwm_out;

  localparam int P  = 1000;
  localparam int SH = 16;
`ifdef PID_PWM_DEADTIME_EN
  localparam int DT    = 8;
  localparam bit DT_ON = 1'b1;
`else
  localparam int DT    = 0;
  localparam bit DT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] un = '0;
  logic        valid = 1'b0;
  logic        en = 1'b0;
  logic        pwm;
  logic        pwm_n;
  logic [15:0] duty;
  logic [1:0]  sat;
  logic        pstart;

  int n_cmp = 0;
  int n_bad = 0;

  pid_pwm_out #(
    .CNT_NB   (16),
    .PERIOD   (P),
    .UN_SHIFT (SH),
    .DT_CYCLES(8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_un          (un),
    .i_valid       (valid),
    .i_en          (en),
    .o_pwm         (pwm),
    .o_pwm_n       (pwm_n),
    .o_duty        (duty),
    .o_sat         (sat),
    .o_period_start(pstart)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int no_dt, input int with_dt);
    return DT_ON ? with_dt : no_dt;
  endfunction

  // ---------------- behavioural model ----------------
  int       m_pos, m_pending, m_active, m_hi_run, m_lo_run;
  bit       m_flag, m_en_prev;
  bit       e_pwm, e_pwmn, e_ps;
  bit [1:0] e_sat;

  function automatic int sat_model(input logic [31:0] u, output bit [1:0] f);
    int s;
    s = $signed(u) >>> SH;
    if (s < 0) begin f = 2'b01; return 0; end
    if (s > P) begin f = 2'b10; return P; end
    f = 2'b00;
    return s;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pending = 0; m_active = 0; m_hi_run = 0; m_lo_run = 0;
    m_flag = 0; m_en_prev = 0;
    e_pwm = 0; e_pwmn = 0; e_ps = 0; e_sat = 2'b00;
  endtask

  task automatic model_step();
    int       sv;
    bit [1:0] f;
    bit       raw;
    bit       used;
    sv   = sat_model(un, f);
    used = 0;
    if (valid) e_sat = f;
    // a period opens on the first enabled clock: its duty is chosen now
    if (en && !m_en_prev) begin
      m_active = valid ? sv : (m_flag ? m_pending : m_active);
      m_flag   = 0;
      used     = valid;
    end
    raw = en && (m_pos < m_active);
    if (DT_ON) begin
      if (!en) begin
        m_hi_run = 0; m_lo_run = 0;
      end else if (raw) begin
        m_hi_run++; m_lo_run = 0;
      end else begin
        m_lo_run++; m_hi_run = 0;
      end
      e_pwm  = en && (m_hi_run > DT);
      e_pwmn = en && (m_lo_run > DT);
    end else begin
      e_pwm  = raw;
      e_pwmn = en && !raw;
    end
    e_ps = en && (m_pos == 0);
    // last clock of a period: next period's duty is chosen
    if (en && m_pos == P - 1) begin
      m_active = valid ? sv : (m_flag ? m_pending : m_active);
      m_flag   = 0;
      used     = valid;
    end
    if (valid && !used) begin
      m_pending = sv;
      m_flag    = 1;
    end
    m_pos     = en ? (m_pos + 1) % P : 0;
    m_en_prev = en;
  endtask

  initial model_reset();

  always @(posedge clk) if (rst_n) model_step();

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("pwm", 32'(pwm), 32'(e_pwm));
      check("pwm_n", 32'(pwm_n), 32'(e_pwmn));
      check("duty", 32'(duty), 32'(m_active));
      check("sat", 32'(sat), 32'(e_sat));
      check("period_start", 32'(pstart), 32'(e_ps));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_at(input int pos);
    int g = 0;
    while (m_pos != pos && g < 3 * P) begin
      tick();
      g++;
    end
    check("reach_pos", 32'(m_pos), 32'(pos));
  endtask

  task automatic strobe(input logic [31:0] v);
    valid = 1'b1;
    un    = v;
    tick();
    valid = 1'b0;
  endtask

  task automatic measure(output int hi, output int lo, output int d);
    int guard = 0;
    int both  = 0;
    hi = 0; lo = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (pstart !== 1'b1 && guard < 3 * P);
    check("period_start_seen", 32'(pstart), 32'd1);
    d = int'(duty);
    for (int i = 0; i < P; i++) begin
      if (i > 0) @(negedge clk);
      hi   += int'(pwm);
      lo   += int'(pwm_n);
      both += int'(pwm & pwm_n);
    end
    check("both_high", 32'(both), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int hi, lo, d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_pwm_n", 32'(pwm_n), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_pstart", 32'(pstart), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;

    // scaled sample: duty 50
    drive_at(300);
    strobe(32'h0032_0000);
    check("sat_scaled", 32'(sat), 32'd0);
    measure(hi, lo, d);
    check("duty50", 32'(d), 32'd50);
    check("hi50", 32'(hi), 32'(pick(50, 42)));
    check("lo50", 32'(lo), 32'(pick(950, 942)));

    // short pulse: duty 5 (swallowed with dead time)
    drive_at(100);
    strobe(32'h0005_0000);
    measure(hi, lo, d);
    check("duty5", 32'(d), 32'd5);
    check("hi5", 32'(hi), 32'(pick(5, 0)));
    check("lo5", 32'(lo), 32'(pick(995, 987)));

    // last wins, second strobe on the wrap clock bypasses pending
    drive_at(200);
    strobe(32'h0064_0000);
    check("duty_held", 32'(duty), 32'd5);
    drive_at(999);
    strobe(32'h000A_0000);
    measure(hi, lo, d);
    check("duty10", 32'(d), 32'd10);
    check("hi10", 32'(hi), 32'(pick(10, 2)));
    check("lo10", 32'(lo), 32'(pick(990, 982)));

    // negative sample
    drive_at(400);
    strobe(32'hFFFF_0000);
    check("sat_neg", 32'(sat), 32'd1);
    measure(hi, lo, d);
    check("duty_neg", 32'(d), 32'd0);
    check("hi_neg", 32'(hi), 32'd0);
    check("lo_neg", 32'(lo), 32'd1000);

    // positive saturation; second period is steady-state
    drive_at(400);
    strobe(32'h7FFF_FFFF);
    check("sat_pos", 32'(sat), 32'd2);
    measure(hi, lo, d);
    measure(hi, lo, d);
    check("duty_pos", 32'(d), 32'd1000);
    check("hi_pos", 32'(hi), 32'd1000);
    check("lo_pos", 32'(lo), 32'd0);

    // disable, strobe while idle, re-enable loads pending at once
    drive_at(600);
    en = 1'b0;
    repeat (5) tick();
    strobe(32'h00C8_0000);
    repeat (3) tick();
    check("dis_pwm", 32'(pwm), 32'd0);
    check("dis_pwm_n", 32'(pwm_n), 32'd0);
    check("dis_duty", 32'(duty), 32'd1000);
    en = 1'b1;
    measure(hi, lo, d);
    check("duty_en", 32'(d), 32'd200);
    check("hi_en", 32'(hi), 32'(pick(200, 192)));
    check("lo_en", 32'(lo), 32'(pick(800, 792)));

    // reset mid-period with duty 300
    drive_at(100);
    strobe(32'h012C_0000);
    measure(hi, lo, d);
    check("duty300", 32'(d), 32'd300);
    check("hi300", 32'(hi), 32'(pick(300, 292)));
    drive_at(500);
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm), 32'd0);
    check("arst_pwm_n", 32'(pwm_n), 32'd0);
    check("arst_duty", 32'(duty), 32'd0);
    check("arst_sat", 32'(sat), 32'd0);
    check("arst_pstart", 32'(pstart), 32'd0);
    tick();
    rst_n = 1'b1;
    measure(hi, lo, d);
    check("duty_after_rst", 32'(d), 32'd0);
    check("hi_after_rst", 32'(hi), 32'd0);
    check("lo_after_rst", 32'(lo), 32'(pick(1000, 992)));

    // randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 1499) == 0) en = ~en;
      valid = ($urandom_range(0, 149) == 0) || (m_pos == P - 1 && $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       un = {16'($urandom_range(0, 1100)), 16'($urandom)};
        1:       un = $urandom | 32'h8000_0000;
        2:       un = $urandom;
        default: un = {16'($urandom_range(998, 1002)), 16'($urandom)};
      endcase
      tick();
    end
    valid = 1'b0;
    tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
